// File: rtl/hazard_pkg.sv
// Shared encodings for the execute-stage hazard/forwarding logic of the RV32I pipeline.
package hazard_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;  // register-file read data (RD1E/RD2E)
  localparam fwd_sel_t FWD_WB  = 2'b01;  // writeback result (WD3)
  localparam fwd_sel_t FWD_MEM = 2'b10;  // ALUResultM

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

endpackage

// File: rtl/fwd_sel.sv
// Forward select for one execute-stage source operand; the youngest producer wins.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] RsE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic                  RegWriteM,
  input  logic                  LoadM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteW,
  output fwd_sel_t              Fwd
);

  // NOTE: assigning a default before any branch keeps this combinational;
  // a path that leaves Fwd unassigned would infer a latch.
  always_comb begin
    Fwd = FWD_RF;
    // A load in M has no data yet; its value is picked up from W next cycle.
    if (RegWriteM && !LoadM && (RdM != '0) && (RdM == RsE)) begin
      Fwd = FWD_MEM;
    end else if (RegWriteW && (RdW != '0) && (RdW == RsE)) begin
      Fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit: forwarding selects plus stall/flush control for load-use,
// taken branches and data-memory wait states.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int RESULTSRC_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_ADDR_W-1:0]  Rs1D,
  input  logic [REG_ADDR_W-1:0]  Rs2D,
  input  logic [REG_ADDR_W-1:0]  RdD,
  input  logic                   RegWriteD,
  input  logic [RESULTSRC_W-1:0] ResultSrcD,
  input  logic                   PCSrcE,
  input  logic                   MemReadyM,
  output fwd_sel_t               ForwardAE,
  output fwd_sel_t               ForwardBE,
  output logic                   StallF,
  output logic                   StallD,
  output logic                   StallE,
  output logic                   StallM,
  output logic                   FlushD,
  output logic                   FlushE,
  output logic                   FlushW
);

  logic [REG_ADDR_W-1:0] r_rs1_e, r_rs2_e, r_rd_e, r_rd_m, r_rd_w;
  logic                  r_reg_write_e, r_load_e;
  logic                  r_reg_write_m, r_load_m;
  logic                  r_reg_write_w;

  logic     w_mem_stall;
  logic     w_load_use;
  logic     w_flush_e;
  logic     w_load_d;
  fwd_sel_t w_fwd_a, w_fwd_b;

  assign w_mem_stall = r_load_m & ~MemReadyM;
  assign w_load_use  = r_load_e & r_reg_write_e & (r_rd_e != '0) &
                       ((r_rd_e == Rs1D) | (r_rd_e == Rs2D));
  assign w_flush_e   = w_load_use | PCSrcE;
  assign w_load_d    = (ResultSrcD == RESULTSRC_W'(RESULTSRC_LOAD));

  // NOTE: sequential state uses non-blocking assignments so every stage
  // shifts on the old value of its neighbour; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rs1_e       <= '0;
      r_rs2_e       <= '0;
      r_rd_e        <= '0;
      r_reg_write_e <= 1'b0;
      r_load_e      <= 1'b0;
      r_rd_m        <= '0;
      r_reg_write_m <= 1'b0;
      r_load_m      <= 1'b0;
      r_rd_w        <= '0;
      r_reg_write_w <= 1'b0;
    end else if (w_mem_stall) begin
      // E and M freeze behind the waiting load; W receives a bubble.
      r_rd_w        <= '0;
      r_reg_write_w <= 1'b0;
    end else begin
      r_rd_w        <= r_rd_m;
      r_reg_write_w <= r_reg_write_m;
      r_rd_m        <= r_rd_e;
      r_reg_write_m <= r_reg_write_e;
      r_load_m      <= r_load_e;
      if (w_flush_e) begin
        r_rs1_e       <= '0;
        r_rs2_e       <= '0;
        r_rd_e        <= '0;
        r_reg_write_e <= 1'b0;
        r_load_e      <= 1'b0;
      end else begin
        r_rs1_e       <= Rs1D;
        r_rs2_e       <= Rs2D;
        r_rd_e        <= RdD;
        r_reg_write_e <= RegWriteD;
        r_load_e      <= w_load_d;
      end
    end
  end

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .RsE(r_rs1_e), .RdM(r_rd_m), .RegWriteM(r_reg_write_m), .LoadM(r_load_m),
    .RdW(r_rd_w), .RegWriteW(r_reg_write_w), .Fwd(w_fwd_a)
  );

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .RsE(r_rs2_e), .RdM(r_rd_m), .RegWriteM(r_reg_write_m), .LoadM(r_load_m),
    .RdW(r_rd_w), .RegWriteW(r_reg_write_w), .Fwd(w_fwd_b)
  );

  always_comb begin
    ForwardAE = w_fwd_a;
    ForwardBE = w_fwd_b;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (!rst) begin
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
    end else if (w_mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      // A taken branch overrides load-use so the PC loads the target.
      StallF = w_load_use & ~PCSrcE;
      StallD = w_load_use & ~PCSrcE;
      FlushD = PCSrcE;
      FlushE = w_flush_e;
    end
  end

  a_no_fwd_11 : assert property (@(posedge clk) disable iff (!rst)
    (ForwardAE != 2'b11) && (ForwardBE != 2'b11));

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios plus a random instruction stream,
// compared against an instruction-level model of the E/M/W occupancy.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic       RegWriteD;
  logic [1:0] ResultSrcD;
  logic       PCSrcE, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;

  always #5 clk = ~clk;

  hazard_unit #(.REG_ADDR_W(5), .RESULTSRC_W(2)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD),
    .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW)
  );

  // One in-flight instruction as the model sees it; an all-zero value is a bubble.
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } instr_t;

  instr_t in_e = '0, in_m = '0, in_w = '0;
  instr_t nx_e, nx_m, nx_w;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] obs_vec();
    return {5'b0, ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction

  function automatic logic [15:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [3:0] stalls, input logic [2:0] flushes);
    return {5'b0, fa, fb, stalls, flushes};
  endfunction

  // Source of an operand: newest older writer of that register with a value ready.
  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (in_m.wr && !in_m.ld && in_m.rd == rs) return 2'b10;
    if (in_w.wr && in_w.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic model_waiting();
    return in_m.ld && !MemReadyM;
  endfunction

  function automatic logic model_hazard();
    return in_e.ld && in_e.wr && (in_e.rd != 5'd0) && (in_e.rd == Rs1D || in_e.rd == Rs2D);
  endfunction

  function automatic logic [15:0] model_out();
    logic [1:0] fa, fb;
    if (!rst) return mk(2'b00, 2'b00, 4'b0000, 3'b111);
    fa = model_fwd(in_e.rs1);
    fb = model_fwd(in_e.rs2);
    if (model_waiting()) return mk(fa, fb, 4'b1111, 3'b001);
    return mk(fa, fb,
              {model_hazard() && !PCSrcE, model_hazard() && !PCSrcE, 2'b00},
              {PCSrcE, model_hazard() || PCSrcE, 1'b0});
  endfunction

  task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic wr, input logic [1:0] rsrc);
    Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = wr; ResultSrcD = rsrc;
  endtask

  task automatic settle();
    #2;
    check("model", obs_vec(), model_out());
  endtask

  task automatic advance();
    nx_e = in_e; nx_m = in_m; nx_w = in_w;
    if (!rst) begin
      nx_e = '0; nx_m = '0; nx_w = '0;
    end else if (model_waiting()) begin
      nx_w = '0;
    end else begin
      nx_w = in_m;
      nx_m = in_e;
      nx_e = (model_hazard() || PCSrcE) ? '0
           : {Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD == 2'b01};
    end
    @(posedge clk);
    in_e = nx_e; in_m = nx_m; in_w = nx_w;
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      set_d(0, 0, 0, 0, 2'b00);
      settle();
      advance();
    end
  endtask

  initial begin
    rst = 1'b0; PCSrcE = 1'b0; MemReadyM = 1'b1;
    set_d(0, 0, 0, 0, 2'b00);

    // Reset forces outputs.
    for (int i = 0; i < 2; i++) begin
      settle();
      check("rst_out", obs_vec(), mk(2'b00, 2'b00, 4'b0000, 3'b111));
      advance();
    end
    rst = 1'b1;
    nops(1);

    // Back-to-back ALU: add x5 ; sub x7,x5 ; or x8,x5
    set_d(1, 2, 5, 1, 2'b00); settle(); advance();
    set_d(5, 3, 7, 1, 2'b00); settle(); advance();
    set_d(5, 0, 8, 1, 2'b00); settle();
    check("alu_fwd_mem", obs_vec(), mk(2'b10, 2'b00, 4'b0000, 3'b000));
    advance();
    set_d(0, 0, 0, 0, 2'b00); settle();
    check("alu_fwd_wb", obs_vec(), mk(2'b01, 2'b00, 4'b0000, 3'b000));
    advance();
    nops(3);

    // Load-use: lw x6 ; add x11,x1,x6
    set_d(1, 0, 6, 1, 2'b01); settle(); advance();
    set_d(1, 6, 11, 1, 2'b00); settle();
    check("lu_stall", obs_vec(), mk(2'b00, 2'b00, 4'b1100, 3'b010));
    advance();
    settle();
    check("lu_release", obs_vec(), mk(2'b00, 2'b00, 4'b0000, 3'b000));
    advance();
    set_d(0, 0, 0, 0, 2'b00); settle();
    check("lu_fwd_wb", obs_vec(), mk(2'b00, 2'b01, 4'b0000, 3'b000));
    advance();
    nops(3);

    // Taken branch together with a load-use hazard.
    set_d(1, 0, 6, 1, 2'b01); settle(); advance();
    set_d(6, 0, 12, 1, 2'b00); PCSrcE = 1'b1; settle();
    check("br_lu", obs_vec(), mk(2'b00, 2'b00, 4'b0000, 3'b110));
    advance();
    PCSrcE = 1'b0;
    nops(3);

    // x0 is never forwarded.
    set_d(1, 2, 0, 1, 2'b00); settle(); advance();
    set_d(0, 0, 9, 1, 2'b00); settle(); advance();
    set_d(0, 0, 0, 0, 2'b00); settle();
    check("x0_fwd", obs_vec(), mk(2'b00, 2'b00, 4'b0000, 3'b000));
    advance();
    nops(3);

    // Memory wait of three cycles: lw x9 ; nop ; add x10,x9
    set_d(1, 0, 9, 1, 2'b01); settle(); advance();
    set_d(0, 0, 0, 0, 2'b00); settle(); advance();
    set_d(9, 0, 10, 1, 2'b00);
    MemReadyM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("mw_stall", obs_vec(), mk(2'b00, 2'b00, 4'b1111, 3'b001));
      advance();
    end
    MemReadyM = 1'b1;
    settle();
    check("mw_release", obs_vec(), mk(2'b00, 2'b00, 4'b0000, 3'b000));
    advance();
    set_d(0, 0, 0, 0, 2'b00); settle();
    check("mw_w_is_load", obs_vec(), mk(2'b01, 2'b00, 4'b0000, 3'b000));
    advance();
    nops(3);

    // Reset asserted in the middle of a memory wait.
    set_d(1, 0, 9, 1, 2'b01); settle(); advance();
    set_d(0, 0, 0, 0, 2'b00); settle(); advance();
    MemReadyM = 1'b0;
    settle();
    check("rs_pre_stall", obs_vec(), mk(2'b00, 2'b00, 4'b1111, 3'b001));
    rst = 1'b0;
    settle();
    check("rs_forced", obs_vec(), mk(2'b00, 2'b00, 4'b0000, 3'b111));
    advance();
    rst = 1'b1;
    settle();
    check("rs_post", obs_vec(), mk(2'b00, 2'b00, 4'b0000, 3'b000));
    advance();
    MemReadyM = 1'b1;
    nops(2);

    // Random instruction stream against the model.
    for (int i = 0; i < 10000; i++) begin
      rst = ($urandom_range(0, 499) != 0);
      set_d(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)));
      PCSrcE    = ($urandom_range(0, 7) == 0);
      MemReadyM = ($urandom_range(0, 9) < 7);
      settle();
      check("no_fwd_11", {15'b0, (ForwardAE == 2'b11) || (ForwardBE == 2'b11)}, 16'h0000);
      advance();
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
